// File: rtl/rgb_mixer_n.sv
// N-channel quadrature-encoder to PWM mixer: per-input synchroniser and debouncer,
// x1 detent decoder with saturating or wrapping level, shared phase-aligned PWM counter.
module rgb_mixer_n #(
  parameter int CHANNELS      = 3,
  parameter int WIDTH         = 8,
  parameter int DEBOUNCE_BITS = 8,
  parameter int STEP          = 1,
  parameter int SATURATE      = 1,
  parameter int INIT_LEVEL    = 0
) (
  input  logic                      clk,
  input  logic                      reset_n,
  input  logic [CHANNELS-1:0]       enc_a,
  input  logic [CHANNELS-1:0]       enc_b,
  output logic [CHANNELS*WIDTH-1:0] level,
  output logic [CHANNELS-1:0]       pwm_out
);

  localparam int              NB     = 2 * CHANNELS;
  localparam logic [WIDTH-1:0] INIT_W = WIDTH'(INIT_LEVEL);
  localparam logic [WIDTH-1:0] MAX_W  = {WIDTH{1'b1}};
  localparam logic [WIDTH:0]   STEP_W = (WIDTH + 1)'(STEP);

  // Inputs are handled uniformly: bits [CHANNELS-1:0] are A phases, the rest B phases.
  logic [NB-1:0] raw;
  logic [NB-1:0] db;
  assign raw = {enc_b, enc_a};

  for (genvar gi = 0; gi < NB; gi++) begin : g_deb
    logic                     sync1_reg;
    logic                     sync2_reg;
    logic                     db_reg;
    logic [DEBOUNCE_BITS-1:0] cnt_reg;

    always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
        sync1_reg <= 1'b0;
        sync2_reg <= 1'b0;
        db_reg    <= 1'b0;
        cnt_reg   <= '0;
      end else begin
        sync1_reg <= raw[gi];
        sync2_reg <= sync1_reg;
        if (sync2_reg == db_reg) begin
          cnt_reg <= '0;
        end else if (cnt_reg == {DEBOUNCE_BITS{1'b1}}) begin
          db_reg  <= sync2_reg;
          cnt_reg <= '0;
        end else begin
          cnt_reg <= cnt_reg + 1'b1;
        end
      end
    end

    assign db[gi] = db_reg;
  end

  logic [WIDTH-1:0] pwm_cnt_reg;
  logic             period_end;
  assign period_end = (pwm_cnt_reg == MAX_W);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) pwm_cnt_reg <= '0;
    else          pwm_cnt_reg <= pwm_cnt_reg + 1'b1;
  end

  for (genvar gi = 0; gi < CHANNELS; gi++) begin : g_ch
    logic             prev_a_reg;
    logic [WIDTH-1:0] level_reg;
    logic [WIDTH-1:0] level_next;
    logic [WIDTH-1:0] shadow_reg;
    logic             pwm_reg;
    logic [WIDTH:0]   sum;

    // One extra bit exposes both carry-out on increment and borrow on decrement.
    always_comb begin
      sum        = db[CHANNELS+gi] ? ({1'b0, level_reg} - STEP_W) : ({1'b0, level_reg} + STEP_W);
      level_next = sum[WIDTH-1:0];
      if (sum[WIDTH] && (SATURATE != 0)) begin
        level_next = db[CHANNELS+gi] ? '0 : MAX_W;
      end
    end

    always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
        prev_a_reg <= 1'b0;
        level_reg  <= INIT_W;
        shadow_reg <= INIT_W;
        pwm_reg    <= 1'b0;
      end else begin
        prev_a_reg <= db[gi];
        if (db[gi] && !prev_a_reg) level_reg <= level_next;
        // Shadow takes the pre-update level, so a same-cycle detent lands one period later.
        if (period_end) shadow_reg <= level_reg;
        pwm_reg <= (pwm_cnt_reg < shadow_reg);
      end
    end

    assign level[gi*WIDTH +: WIDTH] = level_reg;
    assign pwm_out[gi]              = pwm_reg;
  end

endmodule

// File: tb/tb_rgb_mixer_n.sv
// Directed bench for rgb_mixer_n: per-cycle comparison against a detent-level model,
// plus literal expectations for saturate/wrap, bounce rejection and async reset.
module tb_rgb_mixer_n;
  localparam int CH   = 3;
  localparam int W    = 8;
  localparam int DB   = 4;
  localparam int PER  = 1 << W;
  localparam int LAT  = 2 + ((1 << DB) - 1) + 1 + 1;  // input change to level update, in edges
  localparam int HOLD = 25;

  logic            clk = 1'b0;
  logic            reset_n;
  logic [CH-1:0]   enc_a, enc_b;
  logic [CH*W-1:0] level;
  logic [CH-1:0]   pwm_out;

  logic [0:0] sa, sb, ea, eb;
  logic [3:0] lvl_s, lvl_w, lvl_e;
  logic [0:0] pwm_s, pwm_w, pwm_e;

  always #5 clk = ~clk;

  rgb_mixer_n #(.CHANNELS(CH), .WIDTH(W), .DEBOUNCE_BITS(DB), .STEP(1), .SATURATE(1), .INIT_LEVEL(0))
    dut (.clk(clk), .reset_n(reset_n), .enc_a(enc_a), .enc_b(enc_b), .level(level), .pwm_out(pwm_out));
  rgb_mixer_n #(.CHANNELS(1), .WIDTH(4), .DEBOUNCE_BITS(DB), .STEP(3), .SATURATE(1), .INIT_LEVEL(14))
    u_sat (.clk(clk), .reset_n(reset_n), .enc_a(sa), .enc_b(sb), .level(lvl_s), .pwm_out(pwm_s));
  rgb_mixer_n #(.CHANNELS(1), .WIDTH(4), .DEBOUNCE_BITS(DB), .STEP(3), .SATURATE(0), .INIT_LEVEL(14))
    u_wrap (.clk(clk), .reset_n(reset_n), .enc_a(sa), .enc_b(sb), .level(lvl_w), .pwm_out(pwm_w));
  rgb_mixer_n #(.CHANNELS(1), .WIDTH(4), .DEBOUNCE_BITS(DB), .STEP(3), .SATURATE(1), .INIT_LEVEL(1))
    u_dec (.clk(clk), .reset_n(reset_n), .enc_a(ea), .enc_b(eb), .level(lvl_e), .pwm_out(pwm_e));

  int vectors = 0;
  int miscompares = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Model: a clean detent moves the level LAT edges after the A rise is driven;
  // each period the duty is whatever level stood when the last period ended.
  int m_level[CH];
  int m_shadow[CH];
  int m_cnt = 0;
  logic [CH-1:0] m_pwm = '0;
  int cyc = 0;
  int ev_due[$];
  int ev_ch[$];
  bit ev_dn[$];
  bit chk_en = 1'b0;

  initial for (int i = 0; i < CH; i++) begin m_level[i] = 0; m_shadow[i] = 0; end

  function automatic int step_sat(input int l, input bit dn);
    int n;
    n = dn ? l - 1 : l + 1;
    if (n < 0) n = 0;
    if (n > PER - 1) n = PER - 1;
    return n;
  endfunction

  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < CH; i++) begin m_level[i] = 0; m_shadow[i] = 0; end
      m_cnt = 0;
      m_pwm = '0;
      ev_due.delete(); ev_ch.delete(); ev_dn.delete();
    end else begin
      cyc++;
      for (int i = 0; i < CH; i++) m_pwm[i] = (m_cnt < m_shadow[i]);
      if (m_cnt == PER - 1) for (int i = 0; i < CH; i++) m_shadow[i] = m_level[i];
      m_cnt = (m_cnt + 1) % PER;
      while (ev_due.size() > 0 && ev_due[0] == cyc) begin
        m_level[ev_ch[0]] = step_sat(m_level[ev_ch[0]], ev_dn[0]);
        void'(ev_due.pop_front()); void'(ev_ch.pop_front()); void'(ev_dn.pop_front());
      end
    end
  end

  always @(negedge clk) begin
    if (chk_en && reset_n) begin
      logic [CH*W-1:0] exp_level;
      for (int i = 0; i < CH; i++) exp_level[i*W +: W] = W'(m_level[i]);
      check("level_vs_model", level, exp_level);
      check("pwm_vs_model", pwm_out, m_pwm);
    end
  end

  task automatic detent(input logic [CH-1:0] mask, input logic [CH-1:0] down);
    logic [CH-1:0] nb;
    @(negedge clk);
    nb = (enc_b & ~mask) | (down & mask);
    if (nb != enc_b) begin
      enc_b = nb;
      repeat (HOLD) @(negedge clk);
    end
    enc_a = enc_a | mask;
    for (int i = 0; i < CH; i++)
      if (mask[i]) begin ev_due.push_back(cyc + LAT); ev_ch.push_back(i); ev_dn.push_back(down[i]); end
    repeat (HOLD) @(negedge clk);
    enc_a = enc_a & ~mask;
    repeat (HOLD) @(negedge clk);
  endtask

  task automatic small_pulse(input bit dec_inst);
    if (dec_inst) ea = 1'b1; else sa = 1'b1;
    repeat (HOLD) @(negedge clk);
    if (dec_inst) ea = 1'b0; else sa = 1'b0;
    repeat (HOLD) @(negedge clk);
  endtask

  task automatic count_high(input int ch, input int cycles, output int n);
    n = 0;
    for (int i = 0; i < cycles; i++) begin
      @(negedge clk);
      if (pwm_out[ch] === 1'b1) n++;
    end
  endtask

  initial begin
    int n;
    bit found;
    reset_n = 1'b0;
    enc_a = '0; enc_b = '0;
    sa = '0; sb = '0; ea = '0; eb = '0;
    repeat (3) @(negedge clk);
    check("reset_level", level, 0);
    check("reset_pwm", pwm_out, 0);
    check("reset_sat_level", lvl_s, 14);
    check("reset_dec_level", lvl_e, 1);
    reset_n = 1'b1;
    chk_en = 1'b1;

    // Main instance idles for 512 cycles while the 4-bit instances are exercised.
    fork
      begin
        count_high(0, 512, n);
        check("idle_pwm_high_cycles", n, 0);
      end
      begin
        small_pulse(1'b0);
        check("sat_inc1", lvl_s, 15);
        check("wrap_inc1", lvl_w, 1);
        small_pulse(1'b0);
        check("sat_inc2", lvl_s, 15);
        check("wrap_inc2", lvl_w, 4);
        eb = 1'b1;
        repeat (HOLD) @(negedge clk);
        small_pulse(1'b1);
        check("sat_dec_from1", lvl_e, 0);
        small_pulse(1'b1);
        check("sat_dec_floor", lvl_e, 0);
      end
    join
    check("idle_level", level, 0);

    repeat (5) detent(3'b001, 3'b000);
    check("inc5_level0", level[7:0], 5);
    repeat (2 * PER) @(negedge clk);
    count_high(0, PER, n);
    check("inc5_duty0", n, 5);

    for (int t = 0; t < 40; t++) begin
      enc_a[1] = ~enc_a[1];
      repeat (5) @(negedge clk);
    end
    enc_a[1] = 1'b0;
    repeat (40) @(negedge clk);
    check("bounce_level1", level[15:8], 0);
    count_high(1, PER, n);
    check("bounce_duty1", n, 0);

    repeat (5) detent(3'b111, 3'b000);
    repeat (5) detent(3'b110, 3'b000);
    check("pre_simul", level, {8'd10, 8'd10, 8'd10});
    detent(3'b101, 3'b100);
    check("simul", level, {8'd9, 8'd10, 8'd11});
    repeat (2 * PER) @(negedge clk);
    count_high(0, PER, n);
    check("simul_duty0", n, 11);

    enc_b = '0;
    repeat (HOLD) @(negedge clk);
    repeat (117) detent(3'b001, 3'b000);
    check("level128", level[7:0], 128);
    repeat (2 * PER) @(negedge clk);
    found = 1'b0;
    for (int i = 0; i < 2 * PER && !found; i++) begin
      @(negedge clk);
      if (m_cnt == 60) found = 1'b1;
    end
    check("found_counter60", found, 1);
    check("pwm_high_at60", pwm_out[0], 1);
    #2 reset_n = 1'b0;
    #1;
    check("async_reset_pwm", pwm_out, 0);
    check("async_reset_level", level, 0);
    @(negedge clk);
    reset_n = 1'b1;
    repeat (300) @(negedge clk);
    check("post_reset_level", level, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
